axil_rd_arbiter: RTL and testbench
==================================

// Module: axil_rd_arbiter
// PURPOSE
// - Shares the direct-mapped cache's single AXI4-lite read port (AR/R subset) among NUM_REQ requesters (e.g. ifetch, load unit).
// - Round-robin arbitration; exactly one transaction outstanding at a time.
// - Routes the R beat back to the requester that won the AR.
// - Sits between CPU-side requesters (s_*) and the cache cpu_ar_* / cpu_r_* ports (m_*).
// PARAMETERS
// - NUM_REQ  2   number of requesters (>=2).
// - ADDR_W   32  AR address width.
// - DATA_W   32  R data width.
// - GID_W    $clog2(NUM_REQ)  grant index width (derived).
// PORTS
// - clk         in   1               clock.
// - rst         in   1               synchronous, active-high reset.
// - s_ar_addr   in   NUM_REQ*ADDR_W  requester addresses; slice i = [i*ADDR_W +: ADDR_W].
// - s_ar_valid  in   NUM_REQ         requester AR valid.
// - s_ar_ready  out  NUM_REQ         requester AR ready (one-hot or zero).
// - s_r_data    out  NUM_REQ*DATA_W  m_r_data replicated to every slice.
// - s_r_resp    out  NUM_REQ*2       m_r_resp replicated to every slice.
// - s_r_valid   out  NUM_REQ         R valid, only the granted bit may be 1.
// - s_r_ready   in   NUM_REQ         requester R ready.
// - m_ar_addr   out  ADDR_W          to cache cpu_ar_addr (registered).
// - m_ar_valid  out  1               to cache cpu_ar_valid (registered).
// - m_ar_ready  in   1               from cache cpu_ar_ready.
// - m_r_data    in   DATA_W          from cache cpu_r_data.
// - m_r_resp    in   2               from cache cpu_r_resp.
// - m_r_valid   in   1               from cache cpu_r_valid.
// - m_r_ready   out  1               to cache cpu_r_ready.
// - busy        out  1               1 whenever state != IDLE.
// - grant_id    out  GID_W           index of the current/last granted requester.
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge):
//   - State goes to IDLE.
//   - m_ar_valid=0, m_ar_addr=0, m_r_ready=0, s_ar_ready=0, s_r_valid=0, busy=0.
//   - grant_id=0; rr pointer last=NUM_REQ-1, so requester 0 wins first.
//   - While rst=1, all s_ar_ready bits are forced 0.
// - FSM IDLE -> ADDR -> DATA -> IDLE.
// - IDLE:
//   - Winner g = first i with s_ar_valid[i], searching last+1, last+2, ... mod NUM_REQ.
//   - s_ar_ready[g]=1 combinationally, same cycle; all other bits 0.
//   - At the posedge: latch addr[g] into m_ar_addr, set grant_id=g and m_ar_valid=1, go to ADDR.
//   - No valid: stay in IDLE with all ready=0.
// - ADDR:
//   - Hold m_ar_valid=1 and m_ar_addr stable until m_ar_ready=1.
//   - On handshake: m_ar_valid<=0, go to DATA.
//   - s_ar_ready is 0 for all requesters.
// - DATA:
//   - m_r_ready = s_r_ready[grant_id] (combinational).
//   - s_r_valid[grant_id] = m_r_valid; other bits 0.
//   - On m_r_valid && m_r_ready: go to IDLE and set last<=grant_id.
// - Latency:
//   - Requester handshake at cycle T gives m_ar_valid=1 at T+1.
//   - R path is zero-latency pass-through.
//   - Minimum turnaround from one grant to the next IDLE grant is 3 cycles.
// - Fairness: a continuously requesting requester is granted within NUM_REQ transactions.
// - s_ar_valid dropped after the grant: no effect, because the address is already latched.
// - m_r_valid arriving in IDLE or ADDR: ignored; m_r_ready=0 and no s_r_valid is driven.
// - Simultaneous requests: resolved purely by the rr pointer; ties never stall.
// - m_r_resp is passed through unmodified; SLVERR/DECERR are not retried.
// - Reset mid-transaction: FSM aborts to IDLE; the shared rst also resets the cache.
// - Width rule: grant_id wraps modulo NUM_REQ; non-power-of-2 NUM_REQ must not select an index >= NUM_REQ.
// TESTING
// - Reset, then req0 reads 0x40; cache ar_ready after 1 cycle, r_data=0xDEADBEEF -> s_r_valid=01, s_r_data[0]=0xDEADBEEF, busy back to 0.
// - req0 and req1 valid together from reset -> grants 0,1,0,1 over 4 transactions; grant_id sequence checked.
// - Only req1 requests, 3 back-to-back -> all 3 granted to 1, no gaps beyond 3-cycle turnaround.
// - s_r_ready[g] held 0 for 5 cycles with m_r_valid=1 -> m_r_ready=0, data held; release -> completes, next grant follows.
// - rst asserted while in ADDR (m_ar_ready stuck 0) -> next cycle m_ar_valid=0, busy=0; new req0 at 0x80 then completes normally.
// - m_r_resp=2'b10 from cache -> s_r_resp of the granted requester = 2'b10; arbiter returns to IDLE.

Source files
------------

// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite read port (AR/R) among NUM_REQ requesters.
// One transaction outstanding at a time; the R beat is routed back to the AR winner.
module axil_rd_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned GID_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*ADDR_W-1:0]   s_ar_addr,
  input  logic [NUM_REQ-1:0]          s_ar_valid,
  output logic [NUM_REQ-1:0]          s_ar_ready,
  output logic [NUM_REQ*DATA_W-1:0]   s_r_data,
  output logic [NUM_REQ*2-1:0]        s_r_resp,
  output logic [NUM_REQ-1:0]          s_r_valid,
  input  logic [NUM_REQ-1:0]          s_r_ready,
  output logic [ADDR_W-1:0]           m_ar_addr,
  output logic                        m_ar_valid,
  input  logic                        m_ar_ready,
  input  logic [DATA_W-1:0]           m_r_data,
  input  logic [1:0]                  m_r_resp,
  input  logic                        m_r_valid,
  output logic                        m_r_ready,
  output logic                        busy,
  output logic [GID_W-1:0]            grant_id
);

  localparam int unsigned SUM_W = GID_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [GID_W-1:0]    last_q, last_d;
  logic [GID_W-1:0]    grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                arv_q, arv_d;

  logic [GID_W-1:0]    win;
  logic                any_valid;
  logic [SUM_W-1:0]    cand;
  logic [ADDR_W-1:0]   win_addr;
  logic [NUM_REQ-1:0]  s_ar_ready_c;
  logic [NUM_REQ-1:0]  s_r_valid_c;
  logic                m_r_ready_c;
  logic                gnt_r_ready;

  // Round-robin search from last+1; descending loop so the nearest candidate wins.
  always_comb begin
    win       = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand = SUM_W'({1'b0, last_q}) + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        if ((cand == SUM_W'(j)) && s_ar_valid[j]) begin
          win       = GID_W'(j);
          any_valid = 1'b1;
        end
      end
    end
  end

  // Address mux and R-ready select by constant-index comparison.
  always_comb begin
    win_addr    = '0;
    gnt_r_ready = 1'b0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (win == GID_W'(j)) begin
        win_addr = s_ar_addr[j*ADDR_W +: ADDR_W];
      end
      if (grant_q == GID_W'(j)) begin
        gnt_r_ready = s_r_ready[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GID_W'(NUM_REQ - 1);
      grant_q <= '0;
      addr_q  <= '0;
      arv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      arv_q   <= arv_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    arv_d        = arv_q;
    s_ar_ready_c = '0;
    s_r_valid_c  = '0;
    m_r_ready_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (win == GID_W'(j)) begin
              s_ar_ready_c[j] = 1'b1;
            end
          end
          addr_d  = win_addr;
          grant_d = win;
          arv_d   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_ar_ready) begin
          arv_d   = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        m_r_ready_c = gnt_r_ready;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
          if (grant_q == GID_W'(j)) begin
            s_r_valid_c[j] = m_r_valid;
          end
        end
        if (m_r_valid && gnt_r_ready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are held low while reset is asserted.
  assign s_ar_ready = rst ? '0 : s_ar_ready_c;
  assign s_r_valid  = rst ? '0 : s_r_valid_c;
  assign m_r_ready  = rst ? 1'b0 : m_r_ready_c;

  assign s_r_data   = {NUM_REQ{m_r_data}};
  assign s_r_resp   = {NUM_REQ{m_r_resp}};
  assign m_ar_addr  = addr_q;
  assign m_ar_valid = arv_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Self-checking bench for axil_rd_arbiter: the bench plays the cache side and
// predicts grants with a round-robin reference model over requester indices.
module tb_axil_rd_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned GW = 1;

  logic              clk;
  logic              rst;
  logic [N*AW-1:0]   s_ar_addr;
  logic [N-1:0]      s_ar_valid;
  logic [N-1:0]      s_ar_ready;
  logic [N*DW-1:0]   s_r_data;
  logic [N*2-1:0]    s_r_resp;
  logic [N-1:0]      s_r_valid;
  logic [N-1:0]      s_r_ready;
  logic [AW-1:0]     m_ar_addr;
  logic              m_ar_valid;
  logic              m_ar_ready;
  logic [DW-1:0]     m_r_data;
  logic [1:0]        m_r_resp;
  logic              m_r_valid;
  logic              m_r_ready;
  logic              busy;
  logic [GW-1:0]     grant_id;

  int checks;
  int errors;
  int model_last;
  time last_start;

  axil_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbitration: first requesting index after the last winner, wrapping.
  function automatic int model_winner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      if (v[(last + k) % int'(N)]) return (last + k) % int'(N);
    end
    return -1;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    s_ar_valid = '0; s_r_ready = '0; m_ar_ready = 1'b0; m_r_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = int'(N) - 1;
  endtask

  // One full transaction with the bench acting as the cache.
  task automatic run_txn(input logic [N-1:0] vmask, input logic [N*AW-1:0] addrs,
                         input int ar_dly, input int r_dly, input int rr_dly,
                         input logic [DW-1:0] data, input logic [1:0] resp, output int g);
    int ge;
    logic [N-1:0] oh;
    logic [AW-1:0] a_exp;
    ge = model_winner(vmask, model_last);
    oh = N'(1) << ge;
    a_exp = addrs[ge*AW +: AW];
    last_start = $time;
    s_ar_addr = addrs; s_ar_valid = vmask; s_r_ready = '0;
    #1;
    checks++;
    if (s_ar_ready !== oh || busy !== 1'b0) begin
      errors++; $display("FAIL ar_ready: got %b busy %b, expected %b busy 0", s_ar_ready, busy, oh);
    end
    @(posedge clk); #1;
    s_ar_valid = '0; s_ar_addr = {$urandom, $urandom};
    checks++;
    if (m_ar_valid !== 1'b1 || m_ar_addr !== a_exp || grant_id !== GW'(ge) || busy !== 1'b1 || s_ar_ready !== '0) begin
      errors++; $display("FAIL ar_issue: got v=%b a=%h gid=%0d busy=%b rdy=%b, expected v=1 a=%h gid=%0d busy=1 rdy=0",
                         m_ar_valid, m_ar_addr, grant_id, busy, s_ar_ready, a_exp, ge);
    end
    for (int i = 0; i < ar_dly; i++) begin
      m_r_valid = 1'b1; s_r_ready = '1; #1;
      checks++;
      if (m_r_ready !== 1'b0 || s_r_valid !== '0) begin
        errors++; $display("FAIL r_in_addr: got m_r_ready=%b s_r_valid=%b, expected 0 and 00", m_r_ready, s_r_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (m_ar_valid !== 1'b1 || m_ar_addr !== a_exp) begin
        errors++; $display("FAIL ar_hold: got v=%b a=%h, expected v=1 a=%h", m_ar_valid, m_ar_addr, a_exp);
      end
    end
    m_r_valid = 1'b0; m_ar_ready = 1'b1;
    @(posedge clk); #1;
    m_ar_ready = 1'b0;
    checks++;
    if (m_ar_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ar_done: got v=%b busy=%b, expected v=0 busy=1", m_ar_valid, busy);
    end
    for (int i = 0; i < r_dly; i++) begin
      s_r_ready = N'($urandom); #1;
      checks++;
      if (s_r_valid !== '0) begin
        errors++; $display("FAIL r_idle_valid: got %b, expected 00", s_r_valid);
      end
      @(posedge clk); #1;
    end
    m_r_valid = 1'b1; m_r_data = data; m_r_resp = resp;
    for (int i = 0; i < rr_dly; i++) begin
      s_r_ready = ~oh; #1;
      checks++;
      if (m_r_ready !== 1'b0 || s_r_valid !== oh || s_r_data[ge*DW +: DW] !== data) begin
        errors++; $display("FAIL r_stall: got m_r_ready=%b s_r_valid=%b data=%h, expected 0 %b %h",
                           m_r_ready, s_r_valid, s_r_data[ge*DW +: DW], oh, data);
      end
      @(posedge clk); #1;
    end
    s_r_ready = oh; #1;
    checks++;
    if (m_r_ready !== 1'b1 || s_r_valid !== oh || s_r_data[ge*DW +: DW] !== data || s_r_resp[ge*2 +: 2] !== resp) begin
      errors++; $display("FAIL r_beat: got m_r_ready=%b s_r_valid=%b data=%h resp=%b, expected 1 %b %h %b",
                         m_r_ready, s_r_valid, s_r_data[ge*DW +: DW], s_r_resp[ge*2 +: 2], oh, data, resp);
    end
    @(posedge clk); #1;
    m_r_valid = 1'b0; s_r_ready = '0; m_r_data = $urandom;
    model_last = ge;
    checks++;
    if (busy !== 1'b0 || grant_id !== GW'(ge)) begin
      errors++; $display("FAIL txn_end: got busy=%b gid=%0d, expected busy=0 gid=%0d", busy, grant_id, ge);
    end
    g = ge;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_ar_valid = '1; s_ar_addr = {$urandom, $urandom};
    @(posedge clk); #1;
    checks++;
    if (m_ar_valid !== 1'b0 || m_ar_addr !== '0 || m_r_ready !== 1'b0 || s_ar_ready !== '0 ||
        s_r_valid !== '0 || busy !== 1'b0 || grant_id !== '0) begin
      errors++; $display("FAIL reset: got v=%b a=%h rr=%b ardy=%b rv=%b busy=%b gid=%0d, expected all 0",
                         m_ar_valid, m_ar_addr, m_r_ready, s_ar_ready, s_r_valid, busy, grant_id);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    int g;
    logic [N*AW-1:0] a;
    a = '0; a[0 +: AW] = 32'h40;
    run_txn(2'b01, a, 1, 0, 0, 32'hDEADBEEF, 2'b00, g);
  endtask

  task automatic test_alternating();
    int g;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      run_txn(2'b11, {$urandom, $urandom}, 0, 0, 0, $urandom, 2'b00, g);
      checks++;
      if (grant_id !== GW'(k % 2)) begin
        errors++; $display("FAIL alt_seq[%0d]: got grant_id %0d, expected %0d", k, grant_id, k % 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int g;
    time prev;
    for (int k = 0; k < 3; k++) begin
      run_txn(2'b10, {$urandom, $urandom}, 0, 0, 0, $urandom, 2'b00, g);
      if (k > 0) begin
        checks++;
        if (last_start - prev != 30) begin
          errors++; $display("FAIL b2b_gap[%0d]: got %0t, expected 30", k, last_start - prev);
        end
      end
      prev = last_start;
    end
  endtask

  task automatic test_r_backpressure();
    int g;
    run_txn(2'b11, {$urandom, $urandom}, 0, 1, 5, 32'hA5A5_0F0F, 2'b00, g);
    run_txn(2'b11, {$urandom, $urandom}, 0, 0, 0, 32'h1234_5678, 2'b01, g);
  endtask

  task automatic test_reset_mid();
    int g;
    logic [N*AW-1:0] a;
    s_ar_valid = 2'b01; s_ar_addr = {$urandom, $urandom};
    @(posedge clk); #1;
    s_ar_valid = '0; m_ar_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (m_ar_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got v=%b busy=%b, expected 0 0", m_ar_valid, busy);
    end
    rst = 1'b0; model_last = int'(N) - 1;
    a = {$urandom, 32'h80};
    run_txn(2'b01, a, 0, 0, 0, $urandom, 2'b00, g);
  endtask

  task automatic test_slverr();
    int g;
    run_txn(2'b11, {$urandom, $urandom}, 1, 0, 0, $urandom, 2'b10, g);
  endtask

  task automatic test_random();
    int g;
    for (int k = 0; k < 20; k++) begin
      run_txn(N'($urandom_range(1, 3)), {$urandom, $urandom}, $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 2'($urandom), g);
    end
  endtask

  initial begin
    checks = 0; errors = 0; model_last = int'(N) - 1; last_start = 0;
    rst = 1'b1; s_ar_addr = '0; s_ar_valid = '0; s_r_ready = '0;
    m_ar_ready = 1'b0; m_r_data = '0; m_r_resp = '0; m_r_valid = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_alternating();
    test_back_to_back();
    test_r_backpressure();
    test_reset_mid();
    test_slverr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
